// File: rtl/l1_rd_port_mb.sv
// l1_rd_port_mb: multi-beat L1 read port for the multi-stream buffer.
//
// A request names a stream (i_rd_sid) and a burst length (i_rd_len = len-1).
// The port latches a base pointer, which is the stream's read pointer plus
// the entries claimed in the same cycle by lower-numbered ports on the same
// stream. It then reports the consumption (len+1 entries) to the pointer-update
// logic and issues one L1 BRAM address beat per entry. A flush of the stream
// before or during issue aborts the request and produces a one-cycle o_drop_v.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   i_rd_v/i_rd_r              request handshake; i_rd_sid, i_rd_len
//   i_cmp_v/_sid/_len          per-port accepted requests this cycle
//   i_ptrs                     current read pointer of every stream
//   i_sreset                   per-stream flush pulse
//   o_req_v/o_req_r/o_req_cnt  one-hot consumption request and its count
//   o_addr_v/o_addr_r          address beat handshake
//   o_addr_ptr/_sid/_last      beat pointer, stream and last-beat flag
//   o_drop_v                   request aborted by a stream flush
//
// Optional build macro L1_RD_PORT_PERF_EN adds saturating counters
// o_perf_beats, o_perf_drops and o_perf_stall.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready for a request
// ST_REQ   | consumption request presented, waiting for o_req_r[sid]
// ST_ISSUE | issuing address beats base..base+len
// ST_DROP  | one-cycle abort pulse after a stream flush
module l1_rd_port_mb #(
  parameter int nstrms    = 64,
  parameter int sid_width = $clog2(nstrms),
  parameter int nports    = 8,
  parameter int portid    = 0,
  parameter int ptr_width = 4,
  parameter int maxlen    = 4,
  parameter int len_width = $clog2(maxlen)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_rd_v,
  output logic                          i_rd_r,
  input  logic [sid_width-1:0]          i_rd_sid,
  input  logic [len_width-1:0]          i_rd_len,
  input  logic [nports-1:0]             i_cmp_v,
  input  logic [nports*sid_width-1:0]   i_cmp_sid,
  input  logic [nports*len_width-1:0]   i_cmp_len,
  input  logic [nstrms*ptr_width-1:0]   i_ptrs,
  input  logic [nstrms-1:0]             i_sreset,
  output logic [nstrms-1:0]             o_req_v,
  input  logic [nstrms-1:0]             o_req_r,
  output logic [len_width:0]            o_req_cnt,
  output logic                          o_addr_v,
  input  logic                          o_addr_r,
  output logic [ptr_width-1:0]          o_addr_ptr,
  output logic [sid_width-1:0]          o_addr_sid,
  output logic                          o_addr_last,
  output logic                          o_drop_v
`ifdef L1_RD_PORT_PERF_EN
  ,
  output logic [31:0]                   o_perf_beats,
  output logic [15:0]                   o_perf_drops,
  output logic [31:0]                   o_perf_stall
`endif
);

  // Wide enough for a pointer plus every lower port's maximum burst.
  localparam int SUM_W = ptr_width + len_width + $clog2(nports) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ISSUE,
    ST_DROP
  } state_t;

  state_t               state_q;
  logic                 rd_r_q;
  logic                 req_v_q;
  logic                 addr_v_q;
  logic                 drop_q;
  logic                 last_q;
  logic [sid_width-1:0] sid_q;
  logic [len_width-1:0] len_q;
  logic [len_width-1:0] beat_q;
  logic [ptr_width-1:0] base_q;
  logic [ptr_width-1:0] addr_ptr_q;
  logic [len_width:0]   cnt_q;

  logic [SUM_W-1:0]     base_sum;
  logic                 srst_hit;
  logic                 accept;

  // Base pointer: own stream pointer plus same-cycle claims of lower ports.
  always_comb begin
    base_sum = SUM_W'(i_ptrs[i_rd_sid*ptr_width +: ptr_width]);
    for (int i = 0; i < portid; i++) begin
      if (i_cmp_v[i] && (i_cmp_sid[i*sid_width +: sid_width] == i_rd_sid)) begin
        base_sum = base_sum + SUM_W'(i_cmp_len[i*len_width +: len_width]) + SUM_W'(1);
      end
    end
  end

  // Only lower ports' claims matter and the sum is truncated to a pointer.
  logic unused_ok;
  assign unused_ok = ^{i_cmp_v, i_cmp_sid, i_cmp_len, base_sum[SUM_W-1:ptr_width]};

  assign srst_hit = i_sreset[sid_q];
  assign accept   = i_rd_v & rd_r_q;

  // A flush of the active stream masks the request or beat in the same cycle,
  // so no handshake can complete on a stream that is being reset.
  assign i_rd_r      = rd_r_q;
  assign o_req_v     = (req_v_q && !srst_hit) ? (nstrms'(1'b1) << sid_q) : '0;
  assign o_req_cnt   = cnt_q;
  assign o_addr_v    = addr_v_q & ~srst_hit;
  assign o_addr_ptr  = addr_ptr_q;
  assign o_addr_sid  = sid_q;
  assign o_addr_last = last_q;
  assign o_drop_v    = drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rd_r_q     <= 1'b0;
      req_v_q    <= 1'b0;
      addr_v_q   <= 1'b0;
      drop_q     <= 1'b0;
      last_q     <= 1'b0;
      sid_q      <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      base_q     <= '0;
      addr_ptr_q <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          drop_q <= 1'b0;
          if (accept) begin
            rd_r_q <= 1'b0;
            sid_q  <= i_rd_sid;
            len_q  <= i_rd_len;
            base_q <= base_sum[ptr_width-1:0];
            cnt_q  <= (len_width+1)'(i_rd_len) + (len_width+1)'(1);
            if (i_sreset[i_rd_sid]) begin
              drop_q  <= 1'b1;
              state_q <= ST_DROP;
            end else begin
              req_v_q <= 1'b1;
              state_q <= ST_REQ;
            end
          end else begin
            rd_r_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (srst_hit) begin
            req_v_q <= 1'b0;
            drop_q  <= 1'b1;
            state_q <= ST_DROP;
          end else if (o_req_r[sid_q]) begin
            req_v_q    <= 1'b0;
            addr_v_q   <= 1'b1;
            addr_ptr_q <= base_q;
            beat_q     <= '0;
            last_q     <= (len_q == '0);
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (srst_hit) begin
            addr_v_q <= 1'b0;
            last_q   <= 1'b0;
            drop_q   <= 1'b1;
            state_q  <= ST_DROP;
          end else if (o_addr_r) begin
            if (last_q) begin
              addr_v_q <= 1'b0;
              last_q   <= 1'b0;
              rd_r_q   <= 1'b1;
              state_q  <= ST_IDLE;
            end else begin
              beat_q     <= beat_q + len_width'(1);
              addr_ptr_q <= addr_ptr_q + ptr_width'(1);
              last_q     <= ((beat_q + len_width'(1)) == len_q);
            end
          end
        end
        ST_DROP: begin
          drop_q  <= 1'b0;
          rd_r_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef L1_RD_PORT_PERF_EN
  logic [31:0] perf_beats_q;
  logic [15:0] perf_drops_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_beats_q <= '0;
      perf_drops_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (o_addr_v && o_addr_r && (perf_beats_q != '1)) begin
        perf_beats_q <= perf_beats_q + 32'd1;
      end
      if (drop_q && (perf_drops_q != '1)) begin
        perf_drops_q <= perf_drops_q + 16'd1;
      end
      if (o_addr_v && !o_addr_r && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign o_perf_beats = perf_beats_q;
  assign o_perf_drops = perf_drops_q;
  assign o_perf_stall = perf_stall_q;
`endif

endmodule

// File: doc/l1_rd_port_mb.md
Name: l1_rd_port_mb

Overview:
- Multi-beat L1 read port for the multi-stream buffer, and the successor of the single-beat read port.
- Each request names a stream and a burst length of 1..maxlen entries. The port computes the base pointer, offset by same-cycle requests from lower-numbered ports on the same stream.
- It reports the consumed entry count to the pointer-update logic, then issues one L1 BRAM address beat per entry.
- It aborts requests whose stream is reset (flushed) before or during issue.
- One instance per read port sits between the read-port arbiter and the L1 BRAM address mux.

Parameters:
- nstrms, 64, number of streams.
- sid_width, $clog2(nstrms), stream id width.
- nports, 8, number of read ports.
- portid, 0, index of this port (0..nports-1).
- ptr_width, 4, pointer width; per-stream depth is 2**ptr_width.
- maxlen, 4, maximum burst length in entries.
- len_width, $clog2(maxlen), burst length field width; encoded as length-1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- i_rd_v  in  1  request valid.
- i_rd_r  out  1  request ready.
- i_rd_sid  in  sid_width  requested stream.
- i_rd_len  in  len_width  burst length minus 1.
- i_cmp_v  in  nports  per-port "request accepted this cycle".
- i_cmp_sid  in  nports*sid_width  per-port accepted sid.
- i_cmp_len  in  nports*len_width  per-port accepted len-1.
- i_ptrs  in  nstrms*ptr_width  current read pointer of each stream.
- i_sreset  in  nstrms  per-stream reset/flush pulse.
- o_req_v  out  nstrms  one-hot consumption request to the pointer-update logic.
- o_req_r  in  nstrms  per-stream consumption ready.
- o_req_cnt  out  len_width+1  entries consumed (len+1).
- o_addr_v  out  1  address beat valid.
- o_addr_r  in  1  address beat ready.
- o_addr_ptr  out  ptr_width  BRAM entry pointer.
- o_addr_sid  out  sid_width  stream of beat.
- o_addr_last  out  1  final beat of burst.
- o_drop_v  out  1  one-cycle pulse: request aborted by stream reset.

Behaviour:
- Reset (reset=0, async):
  - FSM=IDLE; all outputs 0 except i_rd_r.
  - i_rd_r=0 while reset is asserted; i_rd_r=1 from the first clk edge after release.
- FSM states: IDLE, REQ, ISSUE, DROP.
- IDLE:
  - i_rd_r=1.
  - On i_rd_v&i_rd_r, register sid, len and base. Next state is REQ, or DROP if i_sreset[sid] is set that cycle.
- Base pointer:
  - base = (i_ptrs[sid] + sum over i<portid of (i_cmp_v[i] & i_cmp_sid[i]==sid) ? i_cmp_len[i]+1 : 0) mod 2**ptr_width.
  - i_cmp_* is sampled in the accept cycle. The arbiter guarantees lockstep acceptance.
  - For portid=0 the offset is 0.
  - The sum is at full width before truncation.
- REQ:
  - o_req_v[sid]=1 (only that bit); o_req_cnt=len+1.
  - Held stable until o_req_r[sid]. On the handshake, go to ISSUE with beat=0.
  - i_sreset[sid] before the handshake goes to DROP. o_req_v drops the same cycle; no consumption is reported.
- ISSUE:
  - o_addr_v=1; o_addr_ptr=(base+beat) mod 2**ptr_width (wraps); o_addr_sid=sid; o_addr_last=(beat==len).
  - Each o_addr_v&o_addr_r increments beat. On the last handshake, return to IDLE.
  - o_addr_* stays stable while stalled.
  - i_sreset[sid] mid-burst: the current cycle's beat is not issued (o_addr_v forced 0), then DROP. Consumption is already reported; the pointer logic owns that reset.
- DROP: o_drop_v=1 for exactly one cycle, then IDLE.
- Latency:
  - Accept at cycle N gives o_req_v at N+1.
  - First address beat one cycle after the REQ handshake.
  - Minimum burst of 1 with no stalls occupies 3 cycles from accept to IDLE.
- Resets of other streams (i_sreset bits ≠ sid) are ignored.

Optional Feature:
- Macro: L1_RD_PORT_PERF_EN.
- When defined, adds three output ports:
  - o_perf_beats (32 bits): address beats issued.
  - o_perf_drops (16 bits): drops.
  - o_perf_stall (32 bits): cycles with o_addr_v&!o_addr_r.
- Counters are saturating and cleared by reset.
- When not defined, these ports and counters do not exist; the rest of the port behaviour is identical.

Test Plan:
- portid=0, ptr[5]=3, req sid=5 len=2 (3 beats), all ready → o_req_v[5] with cnt=3; beats ptr 3,4,5; last on 5; back to IDLE.
- portid=2, ptr[7]=14, ptr_width=4, cmp: port0 sid7 len=1, port1 sid3 len=0, own sid7 len=1 → base=16 mod 16=0; beats 0,1.
- Wrap: ptr[1]=15, len=3 → beats 15,0,1,2; o_addr_last only on 2.
- o_addr_r low for 4 cycles on beat 1 → o_addr_ptr/sid/last held stable; beat count unchanged.
- i_sreset[5] asserted in REQ → o_req_v cleared, o_drop_v one pulse, i_rd_r=1 next cycle; i_sreset[6] in ISSUE for sid 5 → no effect.
- reset pulled low mid-ISSUE → o_addr_v=0 asynchronously; after release, first request sid=0 len=0 completes normally.
